// File: rtl/cyp_pkg.sv
// Shared types and constants for the FX2 slave-FIFO read path.
// State encoding, endpoint addresses and strobe levels live here.
package cyp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEL  = 3'd1,
    ST_OE   = 3'd2,
    ST_READ = 3'd3,
    ST_DONE = 3'd4
  } cyp_state_t;

  localparam logic [1:0] EP2_ADDR = 2'd0;
  localparam logic [1:0] EP4_ADDR = 2'd1;
  localparam logic [1:0] EP6_ADDR = 2'd2;
  localparam logic [1:0] EP8_ADDR = 2'd3;

  localparam logic STROBE_IDLE = 1'b1;
  localparam logic STROBE_ACT  = 1'b0;

  // Endpoint index -> FIFOADR value.
  function automatic logic [1:0] ep_addr(input int idx);
    logic [1:0] a;
    case (idx)
      0:       a = EP2_ADDR;
      1:       a = EP4_ADDR;
      2:       a = EP6_ADDR;
      default: a = EP8_ADDR;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cyp_rr_arb.sv
// Round-robin endpoint picker: searches upward from ptr (wrapping) for the
// first flagged endpoint; ptr is the index just after the last one served.
module cyp_rr_arb
  import cyp_pkg::*;
#(
  parameter int EP_NUM = 2
) (
  input  logic [EP_NUM-1:0] req,
  input  logic [1:0]        ptr,
  output logic [EP_NUM-1:0] gnt_oh,
  output logic [1:0]        gnt_idx
);

  always_comb begin : pick
    logic              found;
    int                idx;
    logic [EP_NUM-1:0] req_sh;
    gnt_oh  = '0;
    gnt_idx = EP2_ADDR;
    found   = 1'b0;
    idx     = 0;
    req_sh  = '0;
    for (int k = 0; k < EP_NUM; k++) begin
      idx = int'(ptr) + k;
      if (idx >= EP_NUM) idx = idx - EP_NUM;
      req_sh = req >> idx;
      if (!found && req_sh[0]) begin
        found   = 1'b1;
        gnt_oh  = EP_NUM'(1) << idx;
        gnt_idx = ep_addr(idx);
      end
    end
  end

endmodule

// File: rtl/cyp_slave_rd.sv
// FX2 slave-FIFO reader: round-robin over OUT endpoints, streams one packet
// per selection to a downstream sink with sop/eop/short-packet marking.
//
// state | meaning
// IDLE  | wait for enable and any flagged endpoint
// SEL   | FIFOADR driven, TURN_CLKS settle cycles
// OE    | SLOE low one cycle before reading
// READ  | SLRD pulses while flag set, sink ready and packet not full
// DONE  | strobes released, counter cleared, rr pointer advanced
module cyp_slave_rd
  import cyp_pkg::*;
#(
  parameter int DW        = 16,
  parameter int EP_NUM    = 2,
  parameter int PKT_WORDS = 256,
  parameter int TURN_CLKS = 2
) (
  input  logic              cyp_clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [EP_NUM-1:0] usb_flag,
  input  logic [DW-1:0]     usb_fd_i,
  output logic [1:0]        usb_fifoaddr,
  output logic              usb_slcs,
  output logic              usb_sloe,
  output logic              usb_slrd,
  output logic              usb_fd_oe,
  input  logic              out_afull,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  output logic [DW-1:0]     out_data,
  output logic [1:0]        out_ep,
  output logic              short_pkt
);

  localparam int             WCW      = $clog2(PKT_WORDS + 1);
  localparam logic [WCW-1:0] PKT_FULL = WCW'(PKT_WORDS);
  localparam logic [WCW-1:0] PKT_LAST = WCW'(PKT_WORDS - 1);
  localparam logic [1:0]     EP_LAST  = 2'(EP_NUM - 1);

  cyp_state_t        state, state_nxt;
  logic [1:0]        sel;
  logic [1:0]        rr_ptr;
  logic [3:0]        turn_cnt;
  logic [WCW-1:0]    word_cnt;
  logic [EP_NUM-1:0] gnt_oh;
  logic [1:0]        gnt_idx;
  logic              flag_sel;
  logic              rd_en;
  logic              short_set;

  cyp_rr_arb #(.EP_NUM(EP_NUM)) u_arb (
    .req     (usb_flag),
    .ptr     (rr_ptr),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx)
  );

  assign flag_sel  = |(usb_flag & (EP_NUM'(1) << sel));
  assign rd_en     = (state == ST_READ) && flag_sel && !out_afull && (word_cnt < PKT_FULL);
  // Flag lost mid-packet with some words already delivered is a short packet.
  assign short_set = (state == ST_READ) && !flag_sel && (word_cnt != PKT_FULL) && (word_cnt != '0);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (enable && |gnt_oh) state_nxt = ST_SEL;
      ST_SEL:  if (turn_cnt == 4'd0) state_nxt = ST_OE;
      ST_OE:   state_nxt = ST_READ;
      ST_READ: if (word_cnt == PKT_FULL || !flag_sel) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign usb_sloe     = (state == ST_OE || state == ST_READ) ? STROBE_ACT : STROBE_IDLE;
  assign usb_slrd     = rd_en ? STROBE_ACT : STROBE_IDLE;
  assign usb_fd_oe    = usb_sloe;
  assign usb_slcs     = STROBE_ACT;
  assign usb_fifoaddr = sel;

  always_ff @(posedge cyp_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sel      <= EP2_ADDR;
      rr_ptr   <= 2'd0;
      turn_cnt <= 4'd0;
      word_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (state_nxt == ST_SEL) begin
          sel      <= gnt_idx;
          turn_cnt <= 4'(TURN_CLKS - 1);
        end
        ST_SEL:  if (turn_cnt != 4'd0) turn_cnt <= turn_cnt - 4'd1;
        ST_DONE: begin
          word_cnt <= '0;
          rr_ptr   <= (sel == EP_LAST) ? 2'd0 : sel + 2'd1;
        end
        default: ;
      endcase
      if (rd_en) word_cnt <= word_cnt + 1'b1;
    end
  end

  always_ff @(posedge cyp_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_data  <= '0;
      out_ep    <= 2'd0;
      short_pkt <= 1'b0;
    end else begin
      out_valid <= rd_en;
      out_sop   <= rd_en && (word_cnt == '0);
      out_eop   <= rd_en && (word_cnt == PKT_LAST);
      short_pkt <= short_set;
      if (rd_en) begin
        out_data <= usb_fd_i;
        out_ep   <= sel;
      end
    end
  end

endmodule
